// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: BRAM read port, instruction handoff to decode, and control.
// master = fetch unit side, slave = memory/decode/control side.
interface fetch_unit_if;
  logic        o_mem_read;
  logic [13:0] o_mem_address;
  logic [31:0] i_mem_value;
  logic [31:0] o_insn;
  logic [63:0] o_insn_pc;
  logic        o_insn_valid;
  logic        i_insn_ready;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  logic        i_halt;
  logic        o_halted;

  modport master (
    output o_mem_read, o_mem_address, o_insn, o_insn_pc, o_insn_valid, o_halted,
    input  i_mem_value, i_insn_ready, i_redirect, i_redirect_pc, i_halt
  );

  modport slave (
    input  o_mem_read, o_mem_address, o_insn, o_insn_pc, o_insn_valid, o_halted,
    output i_mem_value, i_insn_ready, i_redirect, i_redirect_pc, i_halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential BRAM reads from pc into a small in-order buffer for decode.
// Read data returns one cycle after issue; issue stalls when buffer plus in-flight read is full.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input logic          i_clk,
  input logic          i_rst,
  fetch_unit_if.master bus
);
  localparam int AW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;
  localparam logic [63:0] START_PC = {RESET_PC[63:2], 2'b00};

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] insn;
  } entry_t;

  state_t         state_q;
  logic [63:0]    pc_q, pc_d;
  logic [63:0]    rsp_pc_q;
  logic           inflight_q;
  entry_t         fifo_q [DEPTH];
  logic [AW-1:0]  head_q, tail_q;
  logic [CW-1:0]  count_q, count_d;
  logic [OW-1:0]  occ;
  logic           pop, push, issue;

  always_comb begin
    pop   = (count_q != '0) && bus.i_insn_ready && !bus.i_redirect;
    push  = inflight_q && !bus.i_redirect;
    // A slot freed by this cycle's pop may be refilled, which sustains one fetch per cycle.
    occ   = {1'b0, count_q} + OW'(inflight_q) - OW'(pop);
    issue = (state_q == RUN) && !bus.i_redirect && (occ < OW'(DEPTH));
    count_d = count_q + CW'(push) - CW'(pop);
    pc_d = pc_q;
    if (bus.i_redirect) begin
      pc_d = bus.i_redirect_pc & ~64'd3;
    end else if (issue) begin
      pc_d = pc_q + 64'd4;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      pc_q       <= START_PC;
      rsp_pc_q   <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE:    state_q <= RUN;
        RUN:     if (!bus.i_redirect && bus.i_halt) state_q <= HALT;
        HALT:    if (bus.i_redirect) state_q <= RUN;
        default: state_q <= IDLE;
      endcase
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) begin
        rsp_pc_q <= pc_q;
      end
      if (bus.i_redirect) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          fifo_q[tail_q] <= '{pc: rsp_pc_q, insn: bus.i_mem_value};
          tail_q         <= tail_q + 1'b1;
        end
        if (pop) begin
          head_q <= head_q + 1'b1;
        end
        count_q <= count_d;
      end
    end
  end

  assign bus.o_mem_read    = issue;
  assign bus.o_mem_address = (state_q == IDLE) ? 14'd0 : pc_q[13:0];
  assign bus.o_insn        = fifo_q[head_q].insn;
  assign bus.o_insn_pc     = fifo_q[head_q].pc;
  assign bus.o_insn_valid  = (count_q != '0);
  assign bus.o_halted      = (state_q == HALT) && !inflight_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized ready/redirect/halt traffic,
// checked cycle by cycle against a queue-based reference model.
module tb_fetch_unit;
  localparam int          D0  = 2;
  localparam logic [63:0] RP1 = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus0 ();
  fetch_unit_if bus1 ();

  fetch_unit #(.RESET_PC(64'h0), .DEPTH(D0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0.master));
  fetch_unit #(.RESET_PC(RP1),   .DEPTH(4))  dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1.master));

  function automatic logic [31:0] word_at(input logic [13:0] a);
    return 32'h1000_0000 + {20'h0, a[13:2]};
  endfunction

  // BRAM model: data valid one cycle after the read strobe
  always @(posedge clk) begin
    if (bus0.o_mem_read) bus0.i_mem_value <= word_at(bus0.o_mem_address);
    if (bus1.o_mem_read) bus1.i_mem_value <= word_at(bus1.o_mem_address);
  end

  int n_chk = 0;
  int n_fail = 0;

  // reference model: buffered {pc, insn} entries plus one pending read
  logic [95:0] mq[$];
  bit          m_run, m_halt, m_pend;
  logic [63:0] m_pc, m_pend_pc;

  int          n_reads;
  logic [13:0] last_addr;
  bit          rec;
  int          cyc, first_rd;
  logic [63:0] d0_pc[$];
  logic [63:0] d1_pc[$];
  logic [13:0] d1_addr[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input bit rdy, input bit rd, input logic [63:0] tgt, input bit hl);
    bus0.i_insn_ready = rdy; bus0.i_redirect = rd; bus0.i_redirect_pc = tgt; bus0.i_halt = hl;
    bus1.i_insn_ready = rdy; bus1.i_redirect = rd; bus1.i_redirect_pc = tgt; bus1.i_halt = hl;
  endtask

  task automatic model_reset(input logic [63:0] rp);
    mq.delete();
    m_run = 0; m_halt = 0; m_pend = 0;
    m_pc = {rp[63:2], 2'b00};
    m_pend_pc = '0;
  endtask

  // one clock cycle: drive, check against the model, advance the model at the edge
  task automatic step(input bit rdy, input bit rd, input logic [63:0] tgt, input bit hl);
    bit ev, pop, er;
    drive(rdy, rd, tgt, hl);
    #1;
    ev  = (mq.size() > 0);
    pop = ev && rdy && !rd;
    er  = m_run && !m_halt && !rd && ((mq.size() + int'(m_pend) - int'(pop)) < D0);
    chk("valid", bus0.o_insn_valid, ev);
    if (ev) begin
      chk("insn", bus0.o_insn, mq[0][31:0]);
      chk("insn_pc", bus0.o_insn_pc, mq[0][95:32]);
    end
    chk("mem_read", bus0.o_mem_read, er);
    if (er) chk("mem_addr", bus0.o_mem_address, m_pc[13:0]);
    chk("halted", bus0.o_halted, m_halt && !m_pend);
    if (bus0.o_mem_read) begin
      n_reads++;
      last_addr = bus0.o_mem_address;
    end
    if (rec) begin
      if (bus0.o_mem_read && first_rd < 0) first_rd = cyc;
      if (bus0.o_insn_valid && rdy) d0_pc.push_back(bus0.o_insn_pc);
      if (bus1.o_mem_read) d1_addr.push_back(bus1.o_mem_address);
      if (bus1.o_insn_valid && rdy) d1_pc.push_back(bus1.o_insn_pc);
      cyc++;
    end
    @(posedge clk);
    if (!m_run) begin
      m_run = 1;
    end else if (rd) begin
      mq.delete();
      m_pend = 0;
      m_halt = 0;
      m_pc = {tgt[63:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_pend) mq.push_back({m_pend_pc, word_at(m_pend_pc[13:0])});
      m_pend = er;
      if (er) begin
        m_pend_pc = m_pc;
        m_pc = m_pc + 64'd4;
      end
      if (hl) m_halt = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 64'h0, 0);
    #1;
    chk("rst_valid", bus0.o_insn_valid, 1'b0);
    chk("rst_read", bus0.o_mem_read, 1'b0);
    chk("rst_addr", bus0.o_mem_address, 14'h0);
    chk("rst_insn", bus0.o_insn, 32'h0);
    chk("rst_insn_pc", bus0.o_insn_pc, 64'h0);
    chk("rst_halted", bus0.o_halted, 1'b0);
    chk("rst_addr1", bus1.o_mem_address, 14'h0);
    chk("rst_valid1", bus1.o_insn_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset(64'h0);
  endtask

  initial begin
    // streaming at full rate, plus the wrapping-pc instance
    do_reset();
    rec = 1; cyc = 1; first_rd = -1;
    for (int i = 0; i < 8; i++) step(1, 0, 64'h0, 0);
    rec = 0;
    chk("first_read_cycle", first_rd, 2);
    chk("d0_pops", (d0_pc.size() >= 4), 1'b1);
    for (int i = 0; i < 4; i++) if (i < d0_pc.size()) chk("d0_pop_pc", d0_pc[i], 64'(i * 4));
    chk("d1_reads", (d1_addr.size() >= 2 && d1_pc.size() >= 2), 1'b1);
    if (d1_addr.size() >= 2) begin
      chk("wrap_addr0", d1_addr[0], 14'h3FFC);
      chk("wrap_addr1", d1_addr[1], 14'h0000);
    end
    if (d1_pc.size() >= 2) begin
      chk("wrap_pc0", d1_pc[0], RP1);
      chk("wrap_pc1", d1_pc[1], 64'h0);
    end

    // decode stalled for 10 cycles from a fresh start
    do_reset();
    n_reads = 0;
    for (int i = 0; i < 11; i++) step(0, 0, 64'h0, 0);
    chk("stall_reads", (n_reads <= D0 + 1), 1'b1);
    chk("stall_head", bus0.o_insn, 32'h1000_0000);
    for (int i = 0; i < 8; i++) step(1, 0, 64'h0, 0);

    // redirect while full with a read in flight
    step(0, 1, 64'h0000_0000_0000_0103, 0);
    step(1, 0, 64'h0, 0);
    step(1, 0, 64'h0, 0);
    chk("redir_valid", bus0.o_insn_valid, 1'b1);
    chk("redir_pc", bus0.o_insn_pc, 64'h100);
    for (int i = 0; i < 4; i++) step(1, 0, 64'h0, 0);

    // halt at pc 0x20, drain, then resume at 0x40
    step(0, 1, 64'h20, 0);
    step(0, 0, 64'h0, 1);
    n_reads = 0;
    for (int i = 0; i < 6; i++) step(1, 0, 64'h0, 0);
    chk("halt_reads", n_reads, 0);
    chk("halt_halted", bus0.o_halted, 1'b1);
    chk("halt_drained", bus0.o_insn_valid, 1'b0);
    step(1, 1, 64'h40, 0);
    n_reads = 0;
    step(1, 0, 64'h0, 0);
    chk("resume_reads", n_reads, 1);
    chk("resume_addr", last_addr, 14'h40);
    for (int i = 0; i < 4; i++) step(1, 0, 64'h0, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5,
           {$urandom, $urandom}, $urandom_range(0, 99) < 3);
    end

    // asynchronous reset in the middle of a stream
    step(1, 1, 64'h200, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 64'h0, 0);
    chk("pre_rst_valid", bus0.o_insn_valid, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", bus0.o_insn_valid, 1'b0);
    chk("async_read", bus0.o_mem_read, 1'b0);
    chk("async_addr", bus0.o_mem_address, 14'h0);
    chk("async_insn_pc", bus0.o_insn_pc, 64'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset(64'h0);
    n_reads = 0;
    step(1, 0, 64'h0, 0);
    step(1, 0, 64'h0, 0);
    chk("restart_addr", last_addr, 14'h0);
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 5,
           {$urandom, $urandom}, $urandom_range(0, 99) < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the byte address of the first fetch after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning instruction buffer entries; legal values are 2 and 4.
REQ-003 SHALL have port i_clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port o_mem_read  output  1  meaning the BRAM read strobe.
REQ-006 SHALL have port o_mem_address  output  14  meaning the BRAM byte address, equal to fetch pc[13:0].
REQ-007 SHALL have port i_mem_value  input  32  meaning BRAM read data, valid exactly one cycle after o_mem_read.
REQ-008 SHALL have port o_insn  output  32  meaning the instruction word at the buffer head.
REQ-009 SHALL have port o_insn_pc  output  64  meaning the byte address of o_insn.
REQ-010 SHALL have port o_insn_valid  output  1  meaning the buffer head holds an instruction.
REQ-011 SHALL have port i_insn_ready  input  1  meaning the decode stage accepts the head this cycle.
REQ-012 SHALL have port i_redirect  input  1  meaning a branch or jump redirect pulse.
REQ-013 SHALL have port i_redirect_pc  input  64  meaning the redirect target, sampled when i_redirect=1.
REQ-014 SHALL have port i_halt  input  1  meaning stop issuing fetches.
REQ-015 SHALL have port o_halted  output  1  meaning the unit is in HALT with no read in flight.

Function
REQ-016 SHALL implement states IDLE, RUN and HALT.
REQ-017 SHALL leave IDLE for RUN on the first clock edge after reset deassertion.
REQ-018 SHALL, in RUN, issue a read (o_mem_read=1, o_mem_address=pc[13:0]) in any cycle where count + inflight < DEPTH and i_redirect=0, and SHALL then set pc to pc+4.
REQ-019 SHALL keep the inflight flag set for exactly the one cycle after an issue, and SHALL in that cycle write i_mem_value with its pc into the buffer tail.
REQ-020 SHALL pop the head on a cycle where o_insn_valid=1 and i_insn_ready=1, presenting the next entry the following cycle.
REQ-021 SHALL allow push and pop in the same cycle, leaving count unchanged; count never exceeds DEPTH and never underflows.
REQ-022 SHALL leave o_insn and o_insn_pc unchanged while o_insn_valid=1 and i_insn_ready=0.
REQ-023 SHALL hold o_mem_read=0 when the buffer plus in-flight read is full, giving a sustained throughput of 1 instruction per cycle when i_insn_ready=1.
REQ-024 SHALL, on i_redirect=1, flush all buffer entries, drop any in-flight response, and load pc with {i_redirect_pc[63:2],2'b00}; o_insn_valid is 0 on the next cycle.
REQ-025 SHALL give a redirect priority over a same-cycle pop, push or issue; the first read at the target issues the cycle after the redirect.
REQ-026 SHALL move to HALT when i_halt=1 and i_redirect=0; an in-flight response is still captured, and buffered entries still drain.
REQ-027 SHALL never issue a read in HALT, and SHALL assert o_halted in HALT once inflight=0.
REQ-028 SHALL return from HALT to RUN only on i_redirect=1, which applies REQ-024.
REQ-029 SHALL let pc wrap modulo 2^64 on increment; the address truncates to pc[13:0] with no error signalled.

Reset
REQ-030 SHALL, while i_rst=1, force: state=IDLE; pc=RESET_PC with bits [1:0] cleared; buffer empty; inflight=0; o_mem_read=0; o_mem_address=0; o_insn=0; o_insn_pc=0; o_insn_valid=0; o_halted=0.
REQ-031 SHALL, on reset asserted mid-operation, discard every buffered and in-flight instruction immediately without waiting for a clock edge.

Verification
REQ-032 SHALL cover this scenario: reset, memory word k=32'h1000_0000+k, i_insn_ready=1 -> first read in cycle 2 after reset release, o_insn_pc sequence 0,4,8,12 with one instruction per cycle.
REQ-033 SHALL cover this scenario: i_insn_ready=0 for 10 cycles -> at most DEPTH+1 reads are issued, o_insn stays 32'h1000_0000, and no word is lost or duplicated after ready returns.
REQ-034 SHALL cover this scenario: redirect to 64'h0000_0000_0000_0103 while full with a read in flight -> next o_insn_pc is 64'h100, and no stale word is delivered.
REQ-035 SHALL cover this scenario: i_halt at pc=0x20 -> no o_mem_read afterwards, remaining entries drain, and o_halted=1; a redirect to 0x40 then resumes fetch at 0x40.
REQ-036 SHALL cover this scenario: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> o_mem_address sequence 0x3FFC then 0x0000, with o_insn_pc 64'hFFFF_FFFF_FFFF_FFFC then 0.
REQ-037 SHALL cover this scenario: i_rst pulsed asynchronously between edges mid-stream -> o_insn_valid and o_mem_read drop at once, and fetch restarts at RESET_PC.
